// File: rtl/drain_pkg.sv
// Shared definitions for the result drain: FSM encoding, byte layout of a
// result word on the UART, and the byte selector used by the drain FSM.
package drain_pkg;

   localparam int BYTES_PER_WORD = 3;
   localparam int BUF_W          = BYTES_PER_WORD * 8;

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      TX,
      READ_HI,
      READ_LO,
      FIN
   } drain_state_t;

   // Byte 0 is the most significant byte of the buffer, so words leave MSB first.
   function automatic logic [7:0] pick_byte(input logic [BUF_W-1:0] word_buf,
                                            input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word_buf[23:16];
         2'd1:    b = word_buf[15:8];
         default: b = word_buf[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// UART 8N1 transmitter. A start request is taken when idle or in the last
// clock of a stop bit, so consecutive frames follow with no idle bits.
module uart_tx_8n1 #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_idx;
   logic [7:0]    data;

   // Bit index 0 is the start bit, 1..8 are data LSB first, 9 is the stop bit;
   // tx_done is registered so it is high during the final stop-bit clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         data     <= '0;
      end else begin
         tx_done <= 1'b0;
         if (tx_busy) begin
            if (baud_cnt == CNT_PRE && bit_idx == 4'd9)
               tx_done <= 1'b1;
            if (baud_cnt == CNT_END) begin
               baud_cnt <= '0;
               if (bit_idx == 4'd9) begin
                  if (tx_start) begin
                     tx      <= 1'b0;
                     data    <= tx_data;
                     bit_idx <= '0;
                  end else begin
                     tx      <= 1'b1;
                     tx_busy <= 1'b0;
                  end
               end else begin
                  bit_idx <= bit_idx + 4'd1;
                  tx      <= (bit_idx == 4'd8) ? 1'b1 : data[bit_idx[2:0]];
               end
            end else begin
               baud_cnt <= baud_cnt + 1'b1;
            end
         end else if (tx_start) begin
            tx_busy  <= 1'b1;
            tx       <= 1'b0;
            data     <= tx_data;
            bit_idx  <= '0;
            baud_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/result_uart_drain.sv
// Drains NUM_RESULTS accelerator words after each done rising edge and sends
// each as three MSB-first bytes over UART, pulsing acc_read once per word.
module result_uart_drain
   import drain_pkg::*;
#(
   parameter int WORD_W       = 18,
   parameter int NUM_RESULTS  = 8,
   parameter int CLKS_PER_BIT = 434,
   parameter int READ_HOLD    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_done,
   input  logic [WORD_W-1:0] acc_out,
   output logic              acc_read,
   output logic              tx,
   output logic              busy,
   output logic              drained
);

   localparam int CNT_W  = $clog2(NUM_RESULTS + 1);
   localparam int HOLD_W = $clog2(READ_HOLD + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_RESULTS);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(READ_HOLD - 1);
   localparam logic [1:0]        BYTE_LAST = 2'(BYTES_PER_WORD - 1);

   drain_state_t      state;
   logic              done_q;
   logic              done_d;
   logic              done_rise;
   logic [CNT_W-1:0]  word_cnt;
   logic [CNT_W-1:0]  word_next;
   logic [HOLD_W-1:0] hold_cnt;
   logic [BUF_W-1:0]  word_buf;
   logic [1:0]        byte_idx;
   logic              launch;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic              tx_done;

   assign done_rise = done_q & ~done_d;
   assign word_next = word_cnt + 1'b1;

   // Done synchroniser and edge history; both reset high so a done level
   // already present when reset releases is not mistaken for a new edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q <= 1'b1;
         done_d <= 1'b1;
      end else begin
         done_q <= acc_done;
         done_d <= done_q;
      end
   end

   // The first byte of a word is launched from the registered launch flag;
   // later bytes are chained on tx_done so frames run back to back.
   always_comb begin
      tx_start = 1'b0;
      tx_data  = pick_byte(word_buf, 2'd0);
      if (state == TX) begin
         if (launch && !tx_busy) begin
            tx_start = 1'b1;
         end else if (tx_done && byte_idx != BYTE_LAST) begin
            tx_start = 1'b1;
            tx_data  = pick_byte(word_buf, byte_idx + 2'd1);
         end
      end
   end

   // Drain FSM with registered busy, drained and acc_read outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         drained  <= 1'b0;
         acc_read <= 1'b0;
         word_cnt <= '0;
         hold_cnt <= '0;
         word_buf <= '0;
         byte_idx <= '0;
         launch   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               drained <= 1'b0;
               if (done_rise) begin
                  busy     <= 1'b1;
                  word_cnt <= '0;
                  state    <= SAMPLE;
               end
            end
            SAMPLE: begin
               word_buf <= BUF_W'(acc_out);
               byte_idx <= '0;
               launch   <= 1'b1;
               state    <= TX;
            end
            TX: begin
               launch <= 1'b0;
               if (tx_done) begin
                  if (byte_idx == BYTE_LAST) begin
                     hold_cnt <= '0;
                     acc_read <= 1'b1;
                     state    <= READ_HI;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            READ_HI: begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt <= '0;
                  acc_read <= 1'b0;
                  state    <= READ_LO;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            READ_LO: begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt <= '0;
                  word_cnt <= word_next;
                  if (word_next == CNT_LAST) begin
                     drained <= 1'b1;
                     busy    <= 1'b0;
                     state   <= FIN;
                  end else begin
                     state <= SAMPLE;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            FIN: begin
               drained  <= 1'b0;
               word_cnt <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   uart_tx_8n1 #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk     (clk),
      .rst     (rst),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx      (tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

endmodule

// File: tb/tb_result_uart_drain.sv
// Testbench for result_uart_drain: behavioural 8-word accelerator, a UART
// receiver and read-pulse monitor, and an expected-byte scoreboard.
module tb_result_uart_drain;

   localparam int CPB = 4;
   localparam int RH  = 3;
   localparam int NW  = 8;
   localparam int WW  = 18;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          acc_done = 1'b0;
   logic [WW-1:0] acc_out;
   logic          acc_read;
   logic          tx;
   logic          busy;
   logic          drained;

   int n_cmp = 0;
   int n_bad = 0;

   logic [WW-1:0] words [NW];
   logic [2:0]    rd_ptr;
   logic          acc_read_q;
   logic          model_clear = 1'b1;

   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int         start_q [$];

   int         cyc_now = 0;
   int         frame_cnt = 0;
   int         stop_err = 0;
   int         read_cnt = 0;
   int         bad_len = 0;
   int         drained_cnt = 0;
   int         hi_len = 0;
   logic       rx_active = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte = '0;

   always #5 clk = ~clk;

   result_uart_drain #(
      .WORD_W      (WW),
      .NUM_RESULTS (NW),
      .CLKS_PER_BIT(CPB),
      .READ_HOLD   (RH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .acc_done(acc_done),
      .acc_out (acc_out),
      .acc_read(acc_read),
      .tx      (tx),
      .busy    (busy),
      .drained (drained)
   );

   // Accelerator model: each acc_read rising edge advances the read pointer.
   assign acc_out = words[rd_ptr];

   always @(posedge clk) begin
      cyc_now    <= cyc_now + 1;
      acc_read_q <= acc_read;
      if (model_clear)
         rd_ptr <= '0;
      else if (acc_read && !acc_read_q)
         rd_ptr <= rd_ptr + 3'd1;
   end

   // UART receiver sampling mid-bit on the falling clock edge.
   always @(negedge clk) begin
      if (!rst) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (tx === 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
            start_q.push_back(cyc_now);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == 2 && tx !== 1'b0) begin
            stop_err++;
            rx_active = 1'b0;
         end else if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0) begin
            rx_byte[(rx_cnt - 6) / 4] = tx;
         end else if (rx_cnt == 38) begin
            if (tx !== 1'b1) stop_err++;
            got_q.push_back(rx_byte);
            frame_cnt++;
            rx_active = 1'b0;
         end
      end
   end

   // Read pulse monitor: counts pulses and flags any not RH cycles long.
   always @(negedge clk) begin
      if (!rst) begin
         hi_len = 0;
      end else if (acc_read === 1'b1) begin
         hi_len++;
      end else if (hi_len != 0) begin
         read_cnt++;
         if (hi_len != RH) bad_len++;
         hi_len = 0;
      end
   end

   always @(negedge clk) begin
      if (rst && drained === 1'b1) drained_cnt++;
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic load_pattern(input int kind);
      logic [WW-1:0] basic [NW];
      basic = '{18'h2A5C3, 18'h00001, 18'h3FFFF, 18'h00000,
                18'h1F0F0, 18'h2AAAA, 18'h15555, 18'h0ABCD};
      for (int i = 0; i < NW; i++) begin
         case (kind)
            0:       words[i] = basic[i];
            1:       words[i] = 18'h3FFFF;
            2:       words[i] = WW'($urandom);
            default: words[i] = WW'(i * 18'h09249) ^ 18'h15A5A;
         endcase
      end
   endtask

   task automatic push_expected();
      logic [23:0] t;
      for (int i = 0; i < NW; i++) begin
         t = {6'b0, words[i]};
         exp_q.push_back(t[23:16]);
         exp_q.push_back(t[15:8]);
         exp_q.push_back(t[7:0]);
      end
   endtask

   task automatic wait_drained(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (drained_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (tx !== 1'b1)       begin n_bad++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
      n_cmp++; if (acc_read !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_acc_read: got %b expected 0", acc_read); end
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (drained !== 1'b0)  begin n_bad++; $display("[TB] FAIL reset_drained: got %b expected 0", drained); end
      rst = 1'b1;
      model_clear = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_after_reset: busy %b expected 0", busy); end
   endtask

   task automatic test_basic_drain();
      int  f0, r0, b0, d0, s0, lat;
      bit  ok;
      logic [7:0] e, g;
      load_pattern(0);
      push_expected();
      start_q.delete();
      f0 = frame_cnt; r0 = read_cnt; b0 = bad_len; d0 = drained_cnt; s0 = stop_err;
      acc_done = 1'b1;
      lat = 0;
      while (tx !== 1'b0 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++; if (lat != 4) begin n_bad++; $display("[TB] FAIL start_latency: got %0d cycles expected 4", lat); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL busy_during_drain: got %b expected 1", busy); end
      repeat (3) @(negedge clk);
      acc_done = 1'b0;
      wait_drained(d0 + 1, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL basic_timeout: drained count %0d expected %0d", drained_cnt, d0 + 1); end
      repeat (5) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_cmp++; if (g !== e) begin n_bad++; $display("[TB] FAIL basic_byte: got %h expected %h", g, e); end
      end
      n_cmp++; if (frame_cnt - f0 != 24) begin n_bad++; $display("[TB] FAIL basic_frames: got %0d expected 24", frame_cnt - f0); end
      n_cmp++; if (read_cnt - r0 != 8)   begin n_bad++; $display("[TB] FAIL basic_reads: got %0d expected 8", read_cnt - r0); end
      n_cmp++; if (bad_len != b0)        begin n_bad++; $display("[TB] FAIL basic_read_len: got %0d bad pulses expected 0", bad_len - b0); end
      n_cmp++; if (drained_cnt - d0 != 1) begin n_bad++; $display("[TB] FAIL basic_drained: got %0d pulses expected 1", drained_cnt - d0); end
      n_cmp++; if (stop_err != s0)       begin n_bad++; $display("[TB] FAIL basic_framing: got %0d errors expected 0", stop_err - s0); end
      n_cmp++; if (start_q.size() < 4) begin
         n_bad++; $display("[TB] FAIL basic_starts: got %0d frame starts expected 24", start_q.size());
      end else begin
         n_cmp++; if (start_q[1] - start_q[0] != 10 * CPB) begin n_bad++; $display("[TB] FAIL byte_spacing: got %0d expected %0d", start_q[1] - start_q[0], 10 * CPB); end
         n_cmp++; if (start_q[3] - start_q[0] != 30 * CPB + 2 * RH + 2) begin n_bad++; $display("[TB] FAIL word_period: got %0d expected %0d", start_q[3] - start_q[0], 30 * CPB + 2 * RH + 2); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL busy_after_drain: got %b expected 0", busy); end
      n_cmp++; if (rd_ptr !== 3'd0) begin n_bad++; $display("[TB] FAIL read_pointer_wrap: got %0d expected 0", rd_ptr); end
   endtask

   task automatic test_max_value();
      int  f0, s0, d0;
      bit  ok;
      logic [7:0] e, g;
      load_pattern(1);
      push_expected();
      f0 = frame_cnt; s0 = stop_err; d0 = drained_cnt;
      acc_done = 1'b1;
      repeat (2) @(negedge clk);
      acc_done = 1'b0;
      wait_drained(d0 + 1, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL max_timeout: drained count %0d expected %0d", drained_cnt, d0 + 1); end
      repeat (5) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_cmp++; if (g !== e) begin n_bad++; $display("[TB] FAIL max_byte: got %h expected %h", g, e); end
      end
      n_cmp++; if (frame_cnt - f0 != 24) begin n_bad++; $display("[TB] FAIL max_frames: got %0d expected 24", frame_cnt - f0); end
      n_cmp++; if (stop_err != s0) begin n_bad++; $display("[TB] FAIL max_stop_bits: got %0d errors expected 0", stop_err - s0); end
   endtask

   task automatic test_retrigger_busy();
      int  f0, r0, d0, n;
      bit  ok;
      logic [7:0] e, g;
      load_pattern(2);
      push_expected();
      f0 = frame_cnt; r0 = read_cnt; d0 = drained_cnt;
      acc_done = 1'b1;
      n = 0;
      while (frame_cnt - f0 < 7 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++; if (frame_cnt - f0 < 7) begin n_bad++; $display("[TB] FAIL retrig_wait: got %0d frames expected 7", frame_cnt - f0); end
      acc_done = 1'b0;
      repeat (2) @(negedge clk);
      acc_done = 1'b1;
      wait_drained(d0 + 1, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL retrig_timeout: drained count %0d expected %0d", drained_cnt, d0 + 1); end
      repeat (300) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_cmp++; if (g !== e) begin n_bad++; $display("[TB] FAIL retrig_byte: got %h expected %h", g, e); end
      end
      n_cmp++; if (frame_cnt - f0 != 24) begin n_bad++; $display("[TB] FAIL retrig_frames: got %0d expected 24", frame_cnt - f0); end
      n_cmp++; if (read_cnt - r0 != 8)   begin n_bad++; $display("[TB] FAIL retrig_reads: got %0d expected 8", read_cnt - r0); end
      n_cmp++; if (drained_cnt - d0 != 1) begin n_bad++; $display("[TB] FAIL retrig_drained: got %0d expected 1", drained_cnt - d0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL retrig_busy: got %b expected 0", busy); end
      acc_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int  f0, r0, d0, n, fr;
      bit  ok;
      logic [7:0] e, g;
      load_pattern(3);
      push_expected();
      f0 = frame_cnt; d0 = drained_cnt;
      acc_done = 1'b1;
      n = 0;
      while (!(frame_cnt - f0 == 4 && rx_active && rx_cnt >= 12) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++; if (frame_cnt - f0 != 4) begin n_bad++; $display("[TB] FAIL rst_wait: got %0d frames expected 4", frame_cnt - f0); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if (tx !== 1'b1)       begin n_bad++; $display("[TB] FAIL rst_async_tx: got %b expected 1", tx); end
      n_cmp++; if (acc_read !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_async_acc_read: got %b expected 0", acc_read); end
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("[TB] FAIL rst_async_busy: got %b expected 0", busy); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      fr = frame_cnt;
      repeat (300) @(negedge clk);
      n_cmp++; if (frame_cnt != fr) begin n_bad++; $display("[TB] FAIL rst_no_retrigger: got %0d new frames expected 0", frame_cnt - fr); end
      n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("[TB] FAIL rst_idle_busy: got %b expected 0", busy); end
      n_cmp++; if (drained_cnt != d0) begin n_bad++; $display("[TB] FAIL rst_no_drained: got %0d expected 0", drained_cnt - d0); end
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_cmp++; if (g !== e) begin n_bad++; $display("[TB] FAIL rst_partial_byte: got %h expected %h", g, e); end
      end
      exp_q.delete();
      got_q.delete();
      acc_done = 1'b0;
      model_clear = 1'b1;
      repeat (2) @(negedge clk);
      model_clear = 1'b0;
      load_pattern(0);
      push_expected();
      f0 = frame_cnt; r0 = read_cnt; d0 = drained_cnt;
      acc_done = 1'b1;
      wait_drained(d0 + 1, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL rst_fresh_timeout: drained count %0d expected %0d", drained_cnt, d0 + 1); end
      repeat (5) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_cmp++; if (g !== e) begin n_bad++; $display("[TB] FAIL rst_fresh_byte: got %h expected %h", g, e); end
      end
      n_cmp++; if (frame_cnt - f0 != 24) begin n_bad++; $display("[TB] FAIL rst_fresh_frames: got %0d expected 24", frame_cnt - f0); end
      n_cmp++; if (read_cnt - r0 != 8)   begin n_bad++; $display("[TB] FAIL rst_fresh_reads: got %0d expected 8", read_cnt - r0); end
      acc_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int  f0, r0, d0, n;
      bit  ok;
      logic [7:0] e, g;
      load_pattern(2);
      push_expected();
      f0 = frame_cnt; r0 = read_cnt; d0 = drained_cnt;
      acc_done = 1'b1;
      repeat (2) @(negedge clk);
      acc_done = 1'b0;
      n = 0;
      while (drained !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_first_timeout: drained %b expected 1", drained); end
      @(negedge clk);
      n_cmp++; if (rd_ptr !== 3'd0) begin n_bad++; $display("[TB] FAIL b2b_read_pointer: got %0d expected 0", rd_ptr); end
      load_pattern(3);
      push_expected();
      acc_done = 1'b1;
      wait_drained(d0 + 2, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL b2b_second_timeout: drained count %0d expected %0d", drained_cnt, d0 + 2); end
      repeat (5) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_cmp++; if (g !== e) begin n_bad++; $display("[TB] FAIL b2b_byte: got %h expected %h", g, e); end
      end
      n_cmp++; if (frame_cnt - f0 != 48) begin n_bad++; $display("[TB] FAIL b2b_frames: got %0d expected 48", frame_cnt - f0); end
      n_cmp++; if (read_cnt - r0 != 16)  begin n_bad++; $display("[TB] FAIL b2b_reads: got %0d expected 16", read_cnt - r0); end
      acc_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_done_drop();
      int  f0, r0, d0, n;
      bit  ok;
      logic [7:0] e, g;
      load_pattern(0);
      push_expected();
      f0 = frame_cnt; r0 = read_cnt; d0 = drained_cnt;
      acc_done = 1'b1;
      n = 0;
      while (frame_cnt - f0 < 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      acc_done = 1'b0;
      wait_drained(d0 + 1, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL drop_timeout: drained count %0d expected %0d", drained_cnt, d0 + 1); end
      repeat (5) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_cmp++; if (g !== e) begin n_bad++; $display("[TB] FAIL drop_byte: got %h expected %h", g, e); end
      end
      n_cmp++; if (frame_cnt - f0 != 24) begin n_bad++; $display("[TB] FAIL drop_frames: got %0d expected 24", frame_cnt - f0); end
      n_cmp++; if (read_cnt - r0 != 8)   begin n_bad++; $display("[TB] FAIL drop_reads: got %0d expected 8", read_cnt - r0); end
      n_cmp++; if (got_q.size() != 0)    begin n_bad++; $display("[TB] FAIL drop_extra_bytes: got %0d expected 0", got_q.size()); end
   endtask

   initial begin
      load_pattern(0);
      $display("[TB] starting result_uart_drain bench");
      test_reset();
      test_basic_drain();
      test_max_value();
      test_retrigger_busy();
      test_reset_mid_frame();
      test_back_to_back();
      test_done_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
